bin_to_bcd_seq: RTL and testbench

Parametrised multi-cycle binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per clock. Generalises the fixed 8-bit/3-digit converter to any input width and digit count, adds a signed mode and an overflow flag, and uses valid/ready handshakes on both sides. Sits between arithmetic datapaths and display/UART formatting logic.

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_digit_adj.sv | 16 +
 rtl/bin_to_bcd_seq.sv | 95 +++++++++
 tb/tb_bin_to_bcd_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  // Width of one packed BCD digit.
  localparam int DIGIT_W = 4;

  // Converter control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Decimal digits needed to hold 2^width - 1, i.e. ceil(width * log10(2)).
  // 2^width is never a power of ten, so the ceiling is exact; the fixed-point
  // constant 0.30103 is accurate well past any practical input width.
  function automatic int min_bcd_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble correction cell: a BCD digit above 4 gets 3 added so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adjusted
);

  // Add-3 correction; 4-bit wrap is intentional, no carry between digits.
  always_comb begin
    adjusted = digit;
    if (digit > 4'd4) adjusted = digit + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Multi-cycle binary-to-BCD converter, one input bit per clock (double dabble).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE and out_valid only in DONE; both
// are pure decodes of the state register. Once out_valid rises, bcd/neg/ovf
// stay stable until the edge where out_ready is seen high.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BIN_W-1:0]       bin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                   neg,
  output logic                   ovf,
  output state_t                 state
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(BIN_W - 1);

  // Too few digits is legal: ovf reports values that do not fit.
  if (DIGITS < min_bcd_digits(BIN_W)) begin : g_digit_check
    $info("bin_to_bcd_seq: DIGITS=%0d below %0d needed for BIN_W=%0d; large values raise ovf",
          DIGITS, min_bcd_digits(BIN_W), BIN_W);
  end

  logic [BIN_W-1:0] mag;
  logic [CNT_W-1:0] count;
  logic [BCD_W-1:0] adj;

  // Per-digit add-3 correction applied before every shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (bcd[g*DIGIT_W +: DIGIT_W]),
      .adjusted (adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Control FSM and datapath: load on accept, shift BIN_W times, hold until taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      bcd   <= '0;
      neg   <= 1'b0;
      ovf   <= 1'b0;
      count <= '0;
      mag   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // The most negative input negates to itself, which read as
            // unsigned is exactly its magnitude.
            if ((SIGNED != 0) && bin[BIN_W-1]) begin
              mag <= -bin;
              neg <= 1'b1;
            end else begin
              mag <= bin;
              neg <= 1'b0;
            end
            bcd   <= '0;
            ovf   <= 1'b0;
            count <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd, mag} <= {adj[BCD_W-2:0], mag, 1'b0};
          // A one leaving the top digit means the value needs more digits.
          if (adj[BCD_W-1]) ovf <= 1'b1;
          count <= count + 1'b1;
          if (count == LAST_COUNT) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: four configurations share one clock and
// reset; each step drives a vector and compares against hand-computed values.
module tb_bin_to_bcd_seq;
  import bcd_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Index 0: 8b/3 digits, 1: 16b/5 digits, 2: signed 8b/3 digits, 3: 8b/2 digits.
  logic [3:0]  iv;
  logic [3:0]  ordy;
  logic [15:0] bin_v [4];
  wire  [3:0]  irdy;
  wire  [3:0]  ovl;
  wire  [3:0]  neg_w;
  wire  [3:0]  ovf_w;
  logic [11:0] bcd_a;
  logic [19:0] bcd_b;
  logic [11:0] bcd_c;
  logic [7:0]  bcd_d;
  state_t st_a, st_b, st_c, st_d;

  int n_cmp = 0;
  int n_err = 0;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]), .bin(bin_v[0][7:0]),
    .out_valid(ovl[0]), .out_ready(ordy[0]), .bcd(bcd_a), .neg(neg_w[0]), .ovf(ovf_w[0]), .state(st_a));
  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]), .bin(bin_v[1]),
    .out_valid(ovl[1]), .out_ready(ordy[1]), .bcd(bcd_b), .neg(neg_w[1]), .ovf(ovf_w[1]), .state(st_b));
  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]), .bin(bin_v[2][7:0]),
    .out_valid(ovl[2]), .out_ready(ordy[2]), .bcd(bcd_c), .neg(neg_w[2]), .ovf(ovf_w[2]), .state(st_c));
  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2), .SIGNED(0)) u_d (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(irdy[3]), .bin(bin_v[3][7:0]),
    .out_valid(ovl[3]), .out_ready(ordy[3]), .bcd(bcd_d), .neg(neg_w[3]), .ovf(ovf_w[3]), .state(st_d));

  function automatic logic [19:0] get_bcd(input int k);
    case (k)
      0:       return {8'h0, bcd_a};
      1:       return bcd_b;
      2:       return {8'h0, bcd_c};
      default: return {12'h0, bcd_d};
    endcase
  endfunction

  function automatic logic [1:0] get_state(input int k);
    case (k)
      0:       return st_a;
      1:       return st_b;
      2:       return st_c;
      default: return st_d;
    endcase
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Accept one value on instance k, wait for out_valid, check result and latency.
  task automatic convert(input int k, input logic [15:0] value, input logic [19:0] exp_bcd,
                         input logic exp_neg, input logic exp_ovf, input int exp_lat,
                         input string tag);
    int cyc;
    check({tag, " in_ready before accept"}, 32'(irdy[k]), 32'd1);
    iv[k]    = 1'b1;
    bin_v[k] = value;
    tick();
    iv[k]    = 1'b0;
    bin_v[k] = 16'($urandom);
    cyc = 0;
    while (!ovl[k] && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, " bcd"}, 32'(get_bcd(k)), 32'(exp_bcd));
    check({tag, " neg"}, 32'(neg_w[k]), 32'(exp_neg));
    check({tag, " ovf"}, 32'(ovf_w[k]), 32'(exp_ovf));
  endtask

  // Take the result and confirm the return to IDLE with outputs held.
  task automatic take(input int k, input logic [19:0] exp_bcd, input string tag);
    ordy[k] = 1'b1;
    tick();
    ordy[k] = 1'b0;
    check({tag, " in_ready after take"}, 32'(irdy[k]), 32'd1);
    check({tag, " out_valid after take"}, 32'(ovl[k]), 32'd0);
    check({tag, " bcd held after take"}, 32'(get_bcd(k)), 32'(exp_bcd));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    iv   = '0;
    ordy = '0;
    for (int i = 0; i < 4; i++) bin_v[i] = '0;

    rst_n = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset[%0d] in_ready", k), 32'(irdy[k]), 32'd1);
      check($sformatf("reset[%0d] out_valid", k), 32'(ovl[k]), 32'd0);
      check($sformatf("reset[%0d] bcd", k), 32'(get_bcd(k)), 32'd0);
      check($sformatf("reset[%0d] state", k), 32'(get_state(k)), 32'(IDLE));
    end
    rst_n = 1'b1;
    tick();

    // 8-bit / 3 digits
    convert(0, 16'd255, 20'h00255, 1'b0, 1'b0, 8, "a255");
    take(0, 20'h00255, "a255");
    convert(0, 16'd0, 20'h00000, 1'b0, 1'b0, 8, "a0");
    take(0, 20'h00000, "a0");
    convert(0, 16'd42, 20'h00042, 1'b0, 1'b0, 8, "a42");
    take(0, 20'h00042, "a42");

    // 16-bit / 5 digits
    convert(1, 16'd65535, 20'h65535, 1'b0, 1'b0, 16, "b65535");
    take(1, 20'h65535, "b65535");

    // Back-to-back with out_ready held high: accepts 18 cycles apart.
    ordy[1]  = 1'b1;
    iv[1]    = 1'b1;
    bin_v[1] = 16'd0;
    tick();
    cyc = 0;
    while (!irdy[1] && cyc < 40) begin
      tick();
      cyc++;
    end
    check("b2b accept spacing", 32'(cyc + 1), 32'd18);
    check("b2b bcd zero", 32'(bcd_b), 32'h00000);
    tick();
    iv[1] = 1'b0;
    cyc = 0;
    while (!irdy[1] && cyc < 40) begin
      tick();
      cyc++;
    end
    check("b2b second spacing", 32'(cyc + 1), 32'd18);
    ordy[1] = 1'b0;

    // Signed 8-bit
    convert(2, 16'h0080, 20'h00128, 1'b1, 1'b0, 8, "s80");
    take(2, 20'h00128, "s80");
    convert(2, 16'h00FF, 20'h00001, 1'b1, 1'b0, 8, "sFF");
    take(2, 20'h00001, "sFF");
    convert(2, 16'h007F, 20'h00127, 1'b0, 1'b0, 8, "s7F");
    take(2, 20'h00127, "s7F");

    // Too few digits
    convert(3, 16'd100, 20'h00000, 1'b0, 1'b1, 8, "d100");
    take(3, 20'h00000, "d100");
    convert(3, 16'd99, 20'h00099, 1'b0, 1'b0, 8, "d99");
    take(3, 20'h00099, "d99");

    // Backpressure: result held while out_ready low, input pulses ignored.
    convert(0, 16'd255, 20'h00255, 1'b0, 1'b0, 8, "bp");
    for (int i = 0; i < 5; i++) begin
      iv[0]    = i[0];
      bin_v[0] = 16'd7;
      tick();
      check($sformatf("bp hold out_valid %0d", i), 32'(ovl[0]), 32'd1);
      check($sformatf("bp hold bcd %0d", i), 32'(bcd_a), 32'h255);
      check($sformatf("bp hold neg %0d", i), 32'(neg_w[0]), 32'd0);
      check($sformatf("bp hold in_ready %0d", i), 32'(irdy[0]), 32'd0);
    end
    iv[0] = 1'b0;
    take(0, 20'h00255, "bp");

    // Reset in the middle of a conversion.
    iv[1]    = 1'b1;
    bin_v[1] = 16'd65535;
    tick();
    iv[1] = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    check("mid reset state", 32'(st_b), 32'(IDLE));
    check("mid reset bcd", 32'(bcd_b), 32'h0);
    check("mid reset out_valid", 32'(ovl[1]), 32'd0);
    check("mid reset in_ready", 32'(irdy[1]), 32'd1);
    rst_n = 1'b1;
    tick();
    convert(1, 16'd1234, 20'h01234, 1'b0, 1'b0, 16, "b1234");
    take(1, 20'h01234, "b1234");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
